// File: rtl/vga_scanout.sv
// VGA raster generator with cell-address fetch. Sync/active flags ride a delay line
// matched to the read latency, so colour, syncs and pulses leave aligned per pixel.
module vga_scanout #(
  parameter int   BPP      = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   XSHIFT   = 4,
  parameter int   YSHIFT   = 4,
  parameter int   LATENCY  = 1,
  localparam int  HTOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  VTOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW_RAW   = $clog2(HTOTAL),
  localparam int  VW_RAW   = $clog2(VTOTAL),
  localparam int  HW       = (HW_RAW < 1) ? 1 : HW_RAW,
  localparam int  VW       = (VW_RAW < 1) ? 1 : VW_RAW,
  localparam int  XW_RAW   = $clog2(H_ACTIVE >> XSHIFT),
  localparam int  YW_RAW   = $clog2(V_ACTIVE >> YSHIFT),
  localparam int  XW       = (XW_RAW < 1) ? 1 : XW_RAW,
  localparam int  YW       = (YW_RAW < 1) ? 1 : YW_RAW
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pix_en,
  output logic [XW-1:0]    o_rd_x,
  output logic [YW-1:0]    o_rd_y,
  output logic             o_rd_valid,
  input  logic [3*BPP-1:0] i_rd_data,
  output logic [BPP-1:0]   o_vga_red,
  output logic [BPP-1:0]   o_vga_grn,
  output logic [BPP-1:0]   o_vga_blu,
  output logic             o_vga_hsync,
  output logic             o_vga_vsync,
  output logic             o_vga_active,
  output logic             o_frame_start,
  output logic             o_line_start
);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic line_first;
    logic frame_first;
  } stage_t;

  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;

  logic   w_h_act;
  logic   w_v_act;
  logic   w_active;
  stage_t w_stage;
  stage_t w_tail;

  stage_t r_pipe [LATENCY];

  logic [XW-1:0]    r_rd_x;
  logic [YW-1:0]    r_rd_y;
  logic             r_rd_valid;
  logic [3*BPP-1:0] r_colour;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_active;
  logic             r_line_start;
  logic             r_frame_start;

  // Raster position of the pixel whose address is issued on the next enabled edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (i_pix_en) begin
      if (r_hcount == H_LAST) begin
        r_hcount <= '0;
        if (r_vcount == V_LAST) begin
          r_vcount <= '0;
        end else begin
          r_vcount <= r_vcount + 1'b1;
        end
      end else begin
        r_hcount <= r_hcount + 1'b1;
      end
    end
  end

  assign w_h_act  = (32'(r_hcount) < 32'(H_ACTIVE));
  assign w_v_act  = (32'(r_vcount) < 32'(V_ACTIVE));
  assign w_active = w_h_act && w_v_act;

  assign w_stage.active      = w_active;
  assign w_stage.hsync       = (32'(r_hcount) >= 32'(HS_START)) && (32'(r_hcount) < 32'(HS_END));
  assign w_stage.vsync       = (32'(r_vcount) >= 32'(VS_START)) && (32'(r_vcount) < 32'(VS_END));
  assign w_stage.line_first  = (r_hcount == '0);
  assign w_stage.frame_first = (r_hcount == '0) && (r_vcount == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_x     <= '0;
      r_rd_y     <= '0;
      r_rd_valid <= 1'b0;
    end else if (i_pix_en) begin
      r_rd_valid <= w_active;
      r_rd_x     <= w_active ? XW'(r_hcount >> XSHIFT) : '0;
      r_rd_y     <= w_active ? YW'(r_vcount >> YSHIFT) : '0;
    end
  end

  // Stage 0 loads alongside the address; the output registers form the last stage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else if (i_pix_en) begin
      r_pipe[0] <= w_stage;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_tail = r_pipe[LATENCY-1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_colour <= '0;
      r_hsync  <= ~HS_POL;
      r_vsync  <= ~VS_POL;
      r_active <= 1'b0;
    end else if (i_pix_en) begin
      r_colour <= w_tail.active ? i_rd_data : '0;
      r_hsync  <= w_tail.hsync ? HS_POL : ~HS_POL;
      r_vsync  <= w_tail.vsync ? VS_POL : ~VS_POL;
      r_active <= w_tail.active;
    end
  end

  // Pulses re-evaluate every clk so a disabled cycle always drops them.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= i_pix_en && w_tail.line_first;
      r_frame_start <= i_pix_en && w_tail.frame_first;
    end
  end

  assign o_rd_x        = r_rd_x;
  assign o_rd_y        = r_rd_y;
  assign o_rd_valid    = r_rd_valid;
  assign o_vga_red     = r_colour[3*BPP-1:2*BPP];
  assign o_vga_grn     = r_colour[2*BPP-1:BPP];
  assign o_vga_blu     = r_colour[BPP-1:0];
  assign o_vga_hsync   = r_hsync;
  assign o_vga_vsync   = r_vsync;
  assign o_vga_active  = r_active;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a 16x8 raster: timing, fetch alignment, pix_en
// gating, asynchronous reset, plus a second instance with POL=1 and LATENCY=4.
`timescale 1ns/1ps
module tb_vga_scanout;

  logic clk = 1'b0;
  logic rst;
  logic pix_en;
  always #5 clk = ~clk;

  logic [1:0] rd_x1, rd_x2;
  logic [0:0] rd_y1, rd_y2;
  logic       rd_valid1, rd_valid2;
  logic [5:0] rd_data1, rd_data2;
  logic [1:0] red1, grn1, blu1, red2, grn2, blu2;
  logic       hs1, vs1, act1, ls1, fs1;
  logic       hs2, vs2, act2, ls2, fs2;

  vga_scanout #(
    .BPP(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .XSHIFT(1), .YSHIFT(1), .LATENCY(2)
  ) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_pix_en(pix_en),
    .o_rd_x(rd_x1), .o_rd_y(rd_y1), .o_rd_valid(rd_valid1), .i_rd_data(rd_data1),
    .o_vga_red(red1), .o_vga_grn(grn1), .o_vga_blu(blu1),
    .o_vga_hsync(hs1), .o_vga_vsync(vs1), .o_vga_active(act1),
    .o_frame_start(fs1), .o_line_start(ls1)
  );

  vga_scanout #(
    .BPP(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .XSHIFT(1), .YSHIFT(1), .LATENCY(4)
  ) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_pix_en(pix_en),
    .o_rd_x(rd_x2), .o_rd_y(rd_y2), .o_rd_valid(rd_valid2), .i_rd_data(rd_data2),
    .o_vga_red(red2), .o_vga_grn(grn2), .o_vga_blu(blu2),
    .o_vga_hsync(hs2), .o_vga_vsync(vs2), .o_vga_active(act2),
    .o_frame_start(fs2), .o_line_start(ls2)
  );

  // Cell memories: LATENCY-1 registers after the registered address.
  logic [5:0] m1_q = '0;
  logic [5:0] m2_q [3] = '{default: '0};
  always @(posedge clk) begin
    if (pix_en) begin
      m1_q    <= {3'b000, rd_x1, rd_y1};
      m2_q[0] <= {3'b101, rd_x2, rd_y2};
      m2_q[1] <= m2_q[0];
      m2_q[2] <= m2_q[1];
    end
  end
  assign rd_data1 = m1_q;
  assign rd_data2 = m2_q[2];

  int checks = 0;
  int errors = 0;
  int n      = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (n=%0d)", tag, got, exp, n);
    end
  endtask

  // Packed {hsync, vsync, active, line_start, frame_start, red, grn, blu} for raster pixel p.
  function automatic logic [10:0] exp_pix(input int p, input logic pol, input logic [2:0] tag);
    int  q, h, v;
    logic a;
    logic [5:0] col;
    if (p < 0) return {~pol, ~pol, 9'b0};
    q   = p % 128;
    h   = q % 16;
    v   = q / 16;
    a   = (h < 8) && (v < 4);
    col = a ? {tag, 2'(h / 2), 1'(v / 2)} : 6'b0;
    return {((h >= 10 && h < 13) ? pol : ~pol), ((v >= 5 && v < 7) ? pol : ~pol),
            a, (h == 0), (q == 0), col};
  endfunction

  // Packed {rd_valid, rd_x, rd_y} while pixel p is being addressed.
  function automatic logic [3:0] exp_rd(input int p);
    int q, h, v;
    if (p < 0) return 4'b0;
    q = p % 128;
    h = q % 16;
    v = q / 16;
    if (h < 8 && v < 4) return {1'b1, 2'(h / 2), 1'(v / 2)};
    return 4'b0;
  endfunction

  task automatic step(input logic en);
    logic [10:0] e1, e2;
    pix_en = en;
    @(posedge clk);
    #1;
    cyc++;
    if (en) n++;
    e1 = exp_pix(n - 3, 1'b0, 3'b000);
    e2 = exp_pix(n - 5, 1'b1, 3'b101);
    if (!en) begin
      e1[7:6] = 2'b00;
      e2[7:6] = 2'b00;
    end
    check("out1", {21'b0, hs1, vs1, act1, ls1, fs1, red1, grn1, blu1}, {21'b0, e1});
    check("rd1",  {28'b0, rd_valid1, rd_x1, rd_y1}, {28'b0, exp_rd(n - 1)});
    check("out2", {21'b0, hs2, vs2, act2, ls2, fs2, red2, grn2, blu2}, {21'b0, e2});
    check("rd2",  {28'b0, rd_valid2, rd_x2, rd_y2}, {28'b0, exp_rd(n - 1)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at n=%0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    int fs_prev, fs_period, hs_low, vs_low;
    rst    = 1'b1;
    pix_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out1", {21'b0, hs1, vs1, act1, ls1, fs1, red1, grn1, blu1}, 32'h600);
    check("rst_rd1",  {28'b0, rd_valid1, rd_x1, rd_y1}, 32'h0);
    check("rst_out2", {21'b0, hs2, vs2, act2, ls2, fs2, red2, grn2, blu2}, 32'h000);
    rst = 1'b0;

    fs_prev = -1; fs_period = -1; hs_low = 0; vs_low = 0;
    for (int i = 0; i < 259; i++) begin
      step(1'b1);
      if (fs1) begin
        if (fs_prev >= 0 && fs_period < 0) fs_period = cyc - fs_prev;
        fs_prev = cyc;
      end
      if (n - 3 >= 128 && n - 3 < 144 && !hs1) hs_low++;
      if (n - 3 >= 128 && n - 3 < 256 && (n - 3) % 16 == 0 && !vs1) vs_low++;
      if (n == 11) check("blank_colour", {26'b0, red1, grn1, blu1}, 32'h0);
      if (n == 56) check("pix53_colour", {26'b0, red1, grn1, blu1}, 32'h05);
      if (n == 4)  check("lat4_pre", {25'b0, act2, red2, grn2, blu2}, 32'h00);
      if (n == 5)  check("lat4_first", {25'b0, act2, red2, grn2, blu2}, 32'h68);
    end
    check("hs_low_per_line", hs_low, 3);
    check("vs_low_lines", vs_low, 2);
    check("fs_period", fs_period, 128);

    // Stop with the counters at h=6, v=2, then reset between edges.
    while (n % 128 != 38) step(1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_out1", {21'b0, hs1, vs1, act1, ls1, fs1, red1, grn1, blu1}, 32'h600);
    check("async_rd1",  {28'b0, rd_valid1, rd_x1, rd_y1}, 32'h0);
    check("async_out2", {21'b0, hs2, vs2, act2, ls2, fs2, red2, grn2, blu2}, 32'h000);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    n = 0;
    step(1'b1);
    check("restart_fs_e1", {31'b0, fs1}, 32'h0);
    step(1'b1);
    check("restart_fs_e2", {31'b0, fs1}, 32'h0);
    step(1'b1);
    check("restart_fs_e3", {31'b0, fs1}, 32'h1);

    for (int i = 0; i < 80; i++) step((i % 4 == 0) || (i % 4 == 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
